// File: rtl/des_pkg.sv
// Shared DES constants, state encodings and the standard permutation/substitution tables.
// Bit numbering follows the DES tables: table entry 1 is the MSB of the operand.
package des_pkg;

    localparam int unsigned NUM_ROUNDS = 16;
    localparam int unsigned SUBKEY_W   = 48;
    localparam int unsigned BLOCK_W    = 64;
    localparam int unsigned HALF_W     = BLOCK_W / 2;
    localparam int unsigned KEYS_W     = NUM_ROUNDS * SUBKEY_W;
    localparam int unsigned CNT_W      = $clog2(NUM_ROUNDS);
    localparam int unsigned NUM_SBOX   = 8;

    localparam logic [CNT_W-1:0] LAST_ROUND = CNT_W'(NUM_ROUNDS - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    localparam int unsigned IP_TAB [64] = '{
        58, 50, 42, 34, 26, 18, 10,  2, 60, 52, 44, 36, 28, 20, 12,  4,
        62, 54, 46, 38, 30, 22, 14,  6, 64, 56, 48, 40, 32, 24, 16,  8,
        57, 49, 41, 33, 25, 17,  9,  1, 59, 51, 43, 35, 27, 19, 11,  3,
        61, 53, 45, 37, 29, 21, 13,  5, 63, 55, 47, 39, 31, 23, 15,  7
    };

    localparam int unsigned FP_TAB [64] = '{
        40,  8, 48, 16, 56, 24, 64, 32, 39,  7, 47, 15, 55, 23, 63, 31,
        38,  6, 46, 14, 54, 22, 62, 30, 37,  5, 45, 13, 53, 21, 61, 29,
        36,  4, 44, 12, 52, 20, 60, 28, 35,  3, 43, 11, 51, 19, 59, 27,
        34,  2, 42, 10, 50, 18, 58, 26, 33,  1, 41,  9, 49, 17, 57, 25
    };

    localparam int unsigned E_TAB [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1
    };

    localparam int unsigned P_TAB [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
    };

    // Each box is indexed by row*16 + column.
    localparam int unsigned SBOX [8][64] = '{
        '{14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
           0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
           4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
          15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13},
        '{15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
           3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
           0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
          13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9},
        '{10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
          13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
          13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
           1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12},
        '{ 7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
          13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
          10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
           3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14},
        '{ 2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
          14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
           4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
          11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3},
        '{12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
          10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
           9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
           4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13},
        '{ 4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
          13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
           1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
           6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12},
        '{13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
           1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
           7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
           2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11}
    };

    function automatic logic [BLOCK_W-1:0] des_ip(input logic [BLOCK_W-1:0] x);
        logic [BLOCK_W-1:0] y;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_TAB[i]];
        return y;
    endfunction

    function automatic logic [BLOCK_W-1:0] des_fp(input logic [BLOCK_W-1:0] x);
        logic [BLOCK_W-1:0] y;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_TAB[i]];
        return y;
    endfunction

    function automatic logic [SUBKEY_W-1:0] des_e(input logic [HALF_W-1:0] x);
        logic [SUBKEY_W-1:0] y;
        for (int i = 0; i < 48; i++) y[47-i] = x[32-E_TAB[i]];
        return y;
    endfunction

    function automatic logic [HALF_W-1:0] des_p(input logic [HALF_W-1:0] x);
        logic [HALF_W-1:0] y;
        for (int i = 0; i < 32; i++) y[31-i] = x[32-P_TAB[i]];
        return y;
    endfunction

    // Row comes from the outer two bits of the 6-bit group, column from the middle four.
    function automatic logic [3:0] des_sbox(input int unsigned box, input logic [5:0] b);
        return 4'(SBOX[box][{b[5], b[0], b[4:1]}]);
    endfunction

endpackage

// File: rtl/des_f_function.sv
// DES round function f(R, K): expansion, key mix, S-box substitution and P permutation.
module des_f_function
    import des_pkg::*;
(
    input  logic [HALF_W-1:0]   r_i,
    input  logic [SUBKEY_W-1:0] k_i,
    output logic [HALF_W-1:0]   f_o
);

    logic [SUBKEY_W-1:0] mixed;
    logic [HALF_W-1:0]   sbox_out;

    always_comb begin
        mixed    = des_e(r_i) ^ k_i;
        sbox_out = '0;
        for (int i = 0; i < int'(NUM_SBOX); i++) begin
            sbox_out[HALF_W-1-4*i -: 4] = des_sbox(i, mixed[SUBKEY_W-1-6*i -: 6]);
        end
        f_o = des_p(sbox_out);
    end

endmodule

// File: rtl/des_round_engine.sv
// Iterative DES datapath: one Feistel round per cycle, 16 cycles per block, with a held result.
// Encryption or decryption is selected purely by the order of the supplied subkeys.
module des_round_engine
    import des_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               keys_valid,
    input  logic [KEYS_W-1:0]  round_keys,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] in_block,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] out_block,
    output logic               busy,
    output logic               key_miss
);

    logic [1:0]          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                keys_loaded_q, keys_loaded_d;
    logic [KEYS_W-1:0]   key_q, key_d;
    logic [HALF_W-1:0]   l_q, l_d, r_q, r_d;
    logic [BLOCK_W-1:0]  out_block_q, out_block_d;
    logic                out_valid_q, out_valid_d;
    logic                key_miss_q, key_miss_d;

    logic [SUBKEY_W-1:0] subkey;
    logic [HALF_W-1:0]   f_out;
    logic [HALF_W-1:0]   r_next;
    logic [BLOCK_W-1:0]  ip_block;
    logic                accept;

    assign subkey   = key_q[KEYS_W-1-SUBKEY_W*32'(cnt_q) -: SUBKEY_W];
    assign r_next   = l_q ^ f_out;
    assign ip_block = des_ip(in_block);

    des_f_function u_f (
        .r_i (r_q),
        .k_i (subkey),
        .f_o (f_out)
    );

    assign in_ready  = keys_loaded_q &
                       ((state_q == StIdle) | ((state_q == StDone) & out_ready));
    assign accept    = in_valid & in_ready;
    assign busy      = (state_q == StRun);
    assign out_valid = out_valid_q;
    assign out_block = out_block_q;
    assign key_miss  = key_miss_q;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        keys_loaded_d = keys_loaded_q;
        key_d         = key_q;
        l_d           = l_q;
        r_d           = r_q;
        out_block_d   = out_block_q;
        out_valid_d   = out_valid_q;
        key_miss_d    = 1'b0;

        // A block in flight always finishes with the keys it started with.
        if (keys_valid) begin
            if (state_q == StRun) begin
                key_miss_d = 1'b1;
            end else begin
                key_d         = round_keys;
                keys_loaded_d = 1'b1;
            end
        end

        case (state_q)
            StIdle: begin
                if (accept) begin
                    {l_d, r_d} = ip_block;
                    cnt_d      = '0;
                    state_d    = StRun;
                end
            end
            StRun: begin
                l_d   = r_q;
                r_d   = r_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ROUND) begin
                    // Final swap is folded in: FP is applied to {R16, L16}.
                    out_block_d = des_fp({r_next, r_q});
                    out_valid_d = 1'b1;
                    state_d     = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                    if (accept) begin
                        {l_d, r_d} = ip_block;
                        cnt_d      = '0;
                        state_d    = StRun;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            keys_loaded_q <= 1'b0;
            key_q         <= '0;
            l_q           <= '0;
            r_q           <= '0;
            out_block_q   <= '0;
            out_valid_q   <= 1'b0;
            key_miss_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            keys_loaded_q <= keys_loaded_d;
            key_q         <= key_d;
            l_q           <= l_d;
            r_q           <= r_d;
            out_block_q   <= out_block_d;
            out_valid_q   <= out_valid_d;
            key_miss_q    <= key_miss_d;
        end
    end

endmodule

// File: tb/tb_des_round_engine.sv
// Directed-plus-random bench for des_round_engine against a textbook DES model with its own
// key schedule; IP and E are generated arithmetically and FP is taken as the inverse of IP.
module tb_des_round_engine;

    logic         clk = 1'b0;
    logic         rst;
    logic         keys_valid;
    logic [767:0] round_keys;
    logic         in_valid;
    logic         in_ready;
    logic [63:0]  in_block;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  out_block;
    logic         busy;
    logic         key_miss;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc = 0;
    int acc_cyc = 0;

    always #5 clk = ~clk;

    des_round_engine dut (
        .clk        (clk),
        .rst        (rst),
        .keys_valid (keys_valid),
        .round_keys (round_keys),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_block   (in_block),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_block  (out_block),
        .busy       (busy),
        .key_miss   (key_miss)
    );

    int pc1 [56] = '{57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
                     10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
                     63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
                     14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    int pc2 [48] = '{14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
                     23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
                     41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                     44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    int pperm [32] = '{16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
                        2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
    int sbox [8][64] = '{
        '{14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
           0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
           4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
          15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13},
        '{15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
           3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
           0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
          13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9},
        '{10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
          13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
          13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
           1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12},
        '{ 7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
          13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
          10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
           3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14},
        '{ 2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
          14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
           4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
          11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3},
        '{12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
          10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
           9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
           4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13},
        '{ 4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
          13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
           1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
           6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12},
        '{13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
           1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
           7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
           2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11}
    };

    // IP rows start at 58,60,62,64,57,59,61,63 and step down by 8 across a row.
    function automatic int ip_src(input int i);
        int row = i / 8;
        int col = i % 8;
        int base = (row < 4) ? 58 + 2 * row : 57 + 2 * (row - 4);
        return base - 8 * col;
    endfunction

    // E takes overlapping 6-bit windows starting one bit before each nibble, wrapping around.
    function automatic int e_src(input int j);
        int s = 4 * (j / 6) + (j % 6);
        if (s == 0) s = 32;
        if (s == 33) s = 1;
        return s;
    endfunction

    function automatic logic [31:0] model_f(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s;
        logic [31:0] p;
        int b, row, col;
        for (int j = 0; j < 48; j++) x[47-j] = r[32-e_src(j)];
        x = x ^ k;
        for (int i = 0; i < 8; i++) begin
            b   = int'(x[47-6*i -: 6]);
            row = 2 * ((b >> 5) & 1) + (b & 1);
            col = (b >> 1) & 15;
            s[31-4*i -: 4] = 4'(sbox[i][16*row+col]);
        end
        for (int j = 0; j < 32; j++) p[31-j] = s[32-pperm[j]];
        return p;
    endfunction

    function automatic logic [63:0] model_des(input logic [767:0] ks, input logic [63:0] blk);
        logic [63:0] y, pre, res;
        logic [31:0] l, r, t;
        for (int i = 0; i < 64; i++) y[63-i] = blk[64-ip_src(i)];
        l = y[63:32];
        r = y[31:0];
        for (int rd = 0; rd < 16; rd++) begin
            t = r;
            r = l ^ model_f(r, ks[767-48*rd -: 48]);
            l = t;
        end
        pre = {r, l};
        for (int i = 0; i < 64; i++) res[64-ip_src(i)] = pre[63-i];
        return res;
    endfunction

    function automatic logic [767:0] model_keys(input logic [63:0] key, input bit decrypt);
        logic [27:0]  c, d;
        logic [55:0]  cd;
        logic [47:0]  sk;
        logic [767:0] ks;
        int sh, slot;
        ks = '0;
        for (int i = 0; i < 28; i++) begin
            c[27-i] = key[64-pc1[i]];
            d[27-i] = key[64-pc1[28+i]];
        end
        for (int rd = 0; rd < 16; rd++) begin
            sh = (rd == 0 || rd == 1 || rd == 8 || rd == 15) ? 1 : 2;
            for (int s = 0; s < sh; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            for (int j = 0; j < 48; j++) sk[47-j] = cd[56-pc2[j]];
            slot = decrypt ? 15 - rd : rd;
            ks[767-48*slot -: 48] = sk;
        end
        return ks;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic load_keys(input logic [767:0] ks);
        round_keys = ks;
        keys_valid = 1'b1;
        tick();
        keys_valid = 1'b0;
    endtask

    task automatic start(input string tag, input logic [63:0] blk);
        in_block = blk;
        in_valid = 1'b1;
        check({tag, " in_ready"}, 64'(in_ready), 64'd1);
        tick();
        acc_cyc  = cyc;
        in_valid = 1'b0;
        check({tag, " busy"}, 64'(busy), 64'd1);
    endtask

    task automatic wait_out(input string tag, input logic [63:0] exp);
        int n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check({tag, " latency"}, 64'(cyc - acc_cyc), 64'd16);
        check({tag, " data"}, out_block, exp);
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " drained"}, 64'({out_valid, busy}), 64'd0);
    endtask

    task automatic run_block(input string tag, input logic [63:0] blk, input logic [63:0] exp);
        start(tag, blk);
        wait_out(tag, exp);
        drain(tag);
    endtask

    logic [767:0] ks, ks2;
    logic [63:0]  k, b, ct, held;
    logic [63:0]  bb [3];
    int           n_in, n_out, last_cyc;
    bit           acc;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        keys_valid = 1'b1;
        round_keys = model_keys(64'h133457799BBCDFF1, 1'b0);
        in_valid   = 1'b1;
        in_block   = 64'h0123456789ABCDEF;
        out_ready  = 1'b0;
        tick();
        tick();
        check("reset in_ready", 64'(in_ready), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset out_block", out_block, 64'd0);
        check("reset key_miss", 64'(key_miss), 64'd0);

        // Keys offered only under reset must not count; in_valid alone must not be accepted.
        rst        = 1'b0;
        keys_valid = 1'b0;
        tick();
        tick();
        check("nokeys in_ready", 64'(in_ready), 64'd0);
        check("nokeys busy", 64'(busy), 64'd0);
        in_valid = 1'b0;

        load_keys(model_keys(64'h133457799BBCDFF1, 1'b0));
        run_block("encrypt", 64'h0123456789ABCDEF, 64'h85E813540F0AB405);
        load_keys(model_keys(64'h133457799BBCDFF1, 1'b1));
        run_block("decrypt", 64'h85E813540F0AB405, 64'h0123456789ABCDEF);

        // All-zero vector, then stall the consumer and update keys while the result is held.
        load_keys(model_keys(64'h0, 1'b0));
        start("zero", 64'h0);
        wait_out("zero", 64'h8CA64DE9C1B123A7);
        ks2 = model_keys({$urandom, $urandom}, 1'b0);
        for (int h = 0; h < 5; h++) begin
            if (h == 2) begin
                round_keys = ks2;
                keys_valid = 1'b1;
            end
            tick();
            keys_valid = 1'b0;
            check("hold out_valid", 64'(out_valid), 64'd1);
            check("hold out_block", out_block, 64'h8CA64DE9C1B123A7);
        end
        check("hold key_miss", 64'(key_miss), 64'd0);
        drain("zero");
        b = {$urandom, $urandom};
        run_block("done keyload", b, model_des(ks2, b));

        // Random keys: DUT encryption vs model, then DUT decryption must restore the plaintext.
        for (int t = 0; t < 3; t++) begin
            k  = {$urandom, $urandom};
            b  = {$urandom, $urandom};
            ks = model_keys(k, 1'b0);
            ct = model_des(ks, b);
            load_keys(ks);
            run_block("random enc", b, ct);
            load_keys(model_keys(k, 1'b1));
            run_block("random dec", ct, b);
        end

        // Back-to-back stream with in_valid and out_ready held high.
        ks = model_keys({$urandom, $urandom}, 1'b0);
        load_keys(ks);
        for (int i = 0; i < 3; i++) bb[i] = {$urandom, $urandom};
        n_in      = 0;
        n_out     = 0;
        last_cyc  = 0;
        in_block  = bb[0];
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 120 && n_out < 3; c++) begin
            if (out_valid === 1'b1) begin
                check("b2b data", out_block, model_des(ks, bb[n_out]));
                if (n_out > 0) check("b2b period", 64'(cyc - last_cyc), 64'd17);
                last_cyc = cyc;
                n_out++;
            end
            acc = (in_valid && in_ready);
            tick();
            if (acc) begin
                n_in++;
                if (n_in < 3) in_block = bb[n_in];
                else in_valid = 1'b0;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("b2b accepted", 64'(n_in), 64'd3);
        check("b2b delivered", 64'(n_out), 64'd3);

        // Key update arriving at round 8 is refused and flagged.
        ks  = model_keys({$urandom, $urandom}, 1'b0);
        ks2 = model_keys({$urandom, $urandom}, 1'b0);
        load_keys(ks);
        b = {$urandom, $urandom};
        start("keymiss", b);
        repeat (8) tick();
        round_keys = ks2;
        keys_valid = 1'b1;
        tick();
        keys_valid = 1'b0;
        check("keymiss pulse", 64'(key_miss), 64'd1);
        tick();
        check("keymiss single", 64'(key_miss), 64'd0);
        wait_out("keymiss", model_des(ks, b));
        drain("keymiss");
        b = {$urandom, $urandom};
        run_block("keymiss oldkeys", b, model_des(ks, b));

        // Reset at round 10 discards everything, including the previously held result.
        start("midreset", {$urandom, $urandom});
        repeat (10) tick();
        held = out_block;
        rst  = 1'b1;
        tick();
        rst  = 1'b0;
        check("midreset out_valid", 64'(out_valid), 64'd0);
        check("midreset out_block", out_block, 64'd0);
        check("midreset busy", 64'(busy), 64'd0);
        check("midreset in_ready", 64'(in_ready), 64'd0);
        check("midreset key_miss", 64'(key_miss), 64'd0);
        in_valid = 1'b1;
        tick();
        tick();
        check("midreset nokeys", 64'({in_ready, busy}), 64'd0);
        in_valid = 1'b0;
        load_keys(ks);
        run_block("after reset", held, model_des(ks, held));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
